alu_req_arbiter: RTL and testbench

//   Shares one combinational 8-bit alu instance between two requesters.

---
 rtl/alu_req_arbiter.sv | 161 ++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Optional feature macro: ALU_DIVZERO_CHECK_EN (flag divide-by-zero instead of passing alu_out).
module alu_req_arbiter #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [SEL_W-1:0]  req1_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_carry,
  output logic              rsp_err,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e              state_q, state_d;
  logic                last_grant_q;
  logic                id_q;
  logic [DATA_W-1:0]   alu_a_q, alu_b_q;
  logic [SEL_W-1:0]    alu_sel_q;
  logic                rsp_valid_q, rsp_id_q, rsp_carry_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [CNT_W-1:0]    op_count_q;

  logic                any_valid, grant_id, accept, rsp_hs;
  logic [DATA_W-1:0]   pick_a, pick_b;
  logic [SEL_W-1:0]    pick_sel;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant_id = ~last_grant_q;
    else                          grant_id = req1_valid;
    pick_a   = grant_id ? req1_a   : req0_a;
    pick_b   = grant_id ? req1_b   : req0_b;
    pick_sel = grant_id ? req1_sel : req0_sel;
    accept   = (state_q == IDLE) && any_valid;
    rsp_hs   = (state_q == RESP) && rsp_valid_q && rsp_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state_q == IDLE) && any_valid && !grant_id;
    req1_ready = (state_q == IDLE) && any_valid &&  grant_id;
    busy       = (state_q != IDLE);
  end

`ifdef ALU_DIVZERO_CHECK_EN
  localparam logic [SEL_W-1:0] SEL_DIV = SEL_W'(3);
  logic div_err_q, rsp_err_q;

  // The ALU result is discarded for a flagged divide; all-ones marks the error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_err_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      if (accept) div_err_q <= (pick_sel == SEL_DIV) && (pick_b == '0);
      if (state_q == EXEC) rsp_err_q <= div_err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_data_q  <= div_err_q ? {DATA_W{1'b1}} : alu_out;
      rsp_carry_q <= div_err_q ? 1'b0 : alu_carry;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_data_q  <= alu_out;
      rsp_carry_q <= alu_carry;
    end
  end

  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      op_count_q   <= '0;
    end else begin
      if (accept) begin
        alu_a_q      <= pick_a;
        alu_b_q      <= pick_b;
        alu_sel_q    <= pick_sel;
        id_q         <= grant_id;
        last_grant_q <= grant_id;
      end
      if (state_q == EXEC) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= id_q;
      end
      if (rsp_hs) begin
        rsp_valid_q <= 1'b0;
        op_count_q  <= op_count_q + 1'b1;
      end
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench for alu_req_arbiter with a behavioural ALU and a round-robin reference model.
module tb_alu_req_arbiter;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 4;
  localparam int CNT_W  = 4;

  logic              clk, rst;
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [SEL_W-1:0]  req0_sel, req1_sel;
  logic [DATA_W-1:0] alu_a, alu_b, alu_out;
  logic [SEL_W-1:0]  alu_sel;
  logic              alu_carry;
  logic              rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err, busy;
  logic [DATA_W-1:0] rsp_data;
  logic [CNT_W-1:0]  op_count;

  typedef struct {
    logic       id;
    logic [7:0] data;
    logic       carry;
    logic       err;
  } rsp_t;

  rsp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   expCount = 0;
  bit   modelLast = 1'b1;
  int   rspMode = 1;

  logic [7:0] opA   [2][8];
  logic [7:0] opB   [2][8];
  logic [3:0] opSel [2][8];

  alu_req_arbiter #(.DATA_W(DATA_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .busy(busy), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the shared ALU; returns {carry, result}.
  function automatic logic [8:0] aluFn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    logic [15:0] p;
    p = {8'h00, a} * {8'h00, b};
    case (sel)
      4'd0:    aluFn = {1'b0, a} + {1'b0, b};
      4'd1:    aluFn = {a < b, a - b};
      4'd2:    aluFn = {|p[15:8], p[7:0]};
      4'd3:    aluFn = {1'b0, (b == 8'h00) ? 8'h00 : a / b};
      4'd4:    aluFn = {a[7], a << 1};
      4'd5:    aluFn = {a[0], a >> 1};
      4'd6:    aluFn = {1'b0, a & b};
      4'd7:    aluFn = {1'b0, a | b};
      4'd8:    aluFn = {1'b0, a ^ b};
      4'd9:    aluFn = {1'b0, ~a};
      4'd15:   aluFn = {8'h00, a == b};
      default: aluFn = {1'b0, ~(a ^ b)};
    endcase
  endfunction

  assign {alu_carry, alu_out} = aluFn(alu_a, alu_b, alu_sel);

  function automatic rsp_t expRsp(input logic id, input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    rsp_t r;
    r.id = id;
    {r.carry, r.data} = aluFn(a, b, sel);
    r.err = 1'b0;
`ifdef ALU_DIVZERO_CHECK_EN
    if (sel == 4'd3 && b == 8'h00) begin
      r.data  = 8'hFF;
      r.carry = 1'b0;
      r.err   = 1'b1;
    end
`endif
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    checkOutput({tag, "_busy"},      32'(busy), 0);
    checkOutput({tag, "_alu_regs"},  32'({alu_a, alu_b, alu_sel}), 0);
    checkOutput({tag, "_rsp_flds"},  32'({rsp_id, rsp_data, rsp_carry, rsp_err}), 0);
    checkOutput({tag, "_op_count"},  32'(op_count), 0);
  endtask

  task automatic setOp(input int r, input int k, input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    opA[r][k] = a;
    opB[r][k] = b;
    opSel[r][k] = sel;
  endtask

  task automatic randOps(input int n0, input int n1);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < ((r == 0) ? n0 : n1); k++)
        setOp(r, k, 8'($urandom), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
              4'($urandom_range(0, 15)));
  endtask

  task automatic presentOp(input int r, input int k);
    if (r == 0) begin
      req0_a = opA[0][k]; req0_b = opB[0][k]; req0_sel = opSel[0][k]; req0_valid = 1'b1;
    end else begin
      req1_a = opA[1][k]; req1_b = opB[1][k]; req1_sel = opSel[1][k]; req1_valid = 1'b1;
    end
  endtask

  // Requester r issues its n ops back to back; the model predicts grant order
  // as round robin over whichever requesters still have work pending.
  task automatic applyStimulus(input int n0, input int n1);
    int  rem[2];
    int  sent[2];
    int  tot[2];
    bit  ord[$];
    bit  last, pick, got;
    int  idx, guard;
    tot[0] = n0; tot[1] = n1;
    rem = tot; sent[0] = 0; sent[1] = 0;
    last = modelLast;
    while (rem[0] > 0 || rem[1] > 0) begin
      if (rem[0] > 0 && rem[1] > 0) pick = ~last;
      else                          pick = (rem[1] > 0);
      expQ.push_back(expRsp(pick, opA[pick][sent[pick]], opB[pick][sent[pick]], opSel[pick][sent[pick]]));
      ord.push_back(pick);
      sent[pick]++; rem[pick]--; last = pick;
    end
    modelLast = last;
    sent[0] = 0; sent[1] = 0;
    if (n0 > 0) presentOp(0, 0);
    if (n1 > 0) presentOp(1, 0);
    idx = 0; guard = 0;
    while (idx < ord.size() && guard < 200) begin
      #1;
      if (req0_ready || req1_ready) begin
        checkOutput("ready_onehot", 32'(req0_ready & req1_ready), 0);
        checkOutput("grant_order", 32'(req1_ready), 32'(ord[idx]));
        got = req1_ready;
        @(posedge clk); #1;
        sent[got]++;
        if (sent[got] < tot[got]) presentOp(int'(got), sent[got]);
        else if (got) req1_valid = 1'b0;
        else          req0_valid = 1'b0;
        idx++;
        checkOutput("exec_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("exec_busy", 32'(busy), 1);
        @(posedge clk); #1;
        checkOutput("latency_rsp_valid", 32'(rsp_valid), 1);
        @(negedge clk);
      end else begin
        @(negedge clk);
        guard++;
      end
    end
    if (idx < ord.size()) begin
      checkOutput("grant_timeout", 32'(idx), 32'(ord.size()));
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
  endtask

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rspMode)
        0:       rsp_ready = ($urandom_range(0, 3) != 0);
        1:       rsp_ready = 1'b1;
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every response handshake, checks that a
  // stalled response holds steady and that nobody is granted while busy.
  initial begin
    rsp_t e;
    bit   prevStall;
    logic [10:0] prevRsp;
    bit   stall;
    prevStall = 1'b0;
    prevRsp = '0;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        prevStall = 1'b0;
      end else begin
        if (busy) checkOutput("busy_no_ready", 32'({req0_ready, req1_ready}), 0);
        if (prevStall) begin
          checkOutput("hold_rsp_valid", 32'(rsp_valid), 1);
          checkOutput("hold_rsp_fields", 32'({rsp_id, rsp_data, rsp_carry, rsp_err}), 32'(prevRsp));
        end
        stall = rsp_valid && !rsp_ready;
        prevRsp = {rsp_id, rsp_data, rsp_carry, rsp_err};
        prevStall = stall;
        if (rsp_valid && rsp_ready) begin
          checkOutput("rsp_expected", 32'(expQ.size() > 0), 1);
          if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
            checkOutput("rsp_data", 32'(rsp_data), 32'(e.data));
            checkOutput("rsp_carry", 32'(rsp_carry), 32'(e.carry));
            checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
          end
          expCount = (expCount + 1) % 16;
          @(posedge clk); #1;
          checkOutput("op_count", 32'(op_count), 32'(expCount));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = '0;
    repeat (2) @(negedge clk);
    #1 checkAllZero("reset");
    checkOutput("reset_ready", 32'({req0_ready, req1_ready}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single add from req0");
    setOp(0, 0, 8'd15, 8'd1, 4'd0);
    applyStimulus(1, 0);

    $display("[TB] overflow add with stalled consumer, req1 waiting");
    rspMode = 2;
    setOp(0, 0, 8'd255, 8'd1, 4'd0);
    setOp(1, 0, 8'd9, 8'd4, 4'd1);
    fork
      applyStimulus(1, 1);
      begin repeat (7) @(negedge clk); rspMode = 1; end
    join

    $display("[TB] divide by zero");
    setOp(1, 0, 8'd15, 8'd0, 4'd3);
    applyStimulus(0, 1);

    $display("[TB] reset during EXEC");
    for (int g = 0; g < 100 && (expQ.size() != 0 || busy); g++) @(negedge clk);
    checkOutput("idle_before_reset", 32'(busy), 0);
    req0_a = 8'd7; req0_b = 8'd3; req0_sel = 4'd0; req0_valid = 1'b1;
    #1 checkOutput("rst_test_ready", 32'(req0_ready), 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    checkOutput("rst_test_exec", 32'(busy), 1);
    #2 rst = 1'b1;
    #1 checkAllZero("midreset");
    expCount = 0;
    modelLast = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      checkOutput("rst_no_rsp", 32'(rsp_valid), 0);
    end
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] tie after reset, then alternation with re-request");
    setOp(0, 0, 8'd10, 8'd20, 4'd0);
    setOp(1, 0, 8'd30, 8'd40, 4'd1);
    applyStimulus(1, 1);
    randOps(2, 1);
    applyStimulus(2, 1);

    $display("[TB] back-to-back ops across counter wrap");
    randOps(8, 8);
    applyStimulus(8, 8);

    $display("[TB] randomized traffic");
    rspMode = 0;
    for (int i = 0; i < 25; i++) begin
      int n0, n1;
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      randOps(n0, n1);
      applyStimulus(n0, n1);
    end

    rspMode = 1;
    for (int g = 0; g < 100 && expQ.size() != 0; g++) @(negedge clk);
    repeat (3) @(negedge clk);
    checkOutput("drain", 32'(expQ.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
